// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone GPIO slave with N pins, per-pin direction, input synchroniser,
// optional debounce filter and rising/falling edge interrupts with W1C status.
//
// Register map (byte offset, only wb_adr[4:2] decoded):
//   0x00 DATA_IN RO  | 0x04 DATA_OUT RW | 0x08 DIR RW (1=output)
//   0x0C RISE_EN RW  | 0x10 FALL_EN RW  | 0x14 IRQ_STATUS RW1C
//   0x18/0x1C read 0, writes ignored, still acked.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   wb_cyc/stb/we/sel   Wishbone request qualifiers
//   wb_adr, wb_dat_i    byte address, write data
//   wb_dat_o, wb_ack    registered read data and one-cycle acknowledge
//   wb_stall            tied 0
//   gpio_i              asynchronous pad inputs
//   gpio_o, gpio_oe     pad output values (DATA_OUT) and enables (DIR)
//   irq                 level interrupt, OR of IRQ_STATUS
module wb_gpio #(
  parameter int unsigned N      = 4,
  parameter int unsigned DB_DIV = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [3:0]    wb_sel,
  input  logic [31:0]   wb_adr,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack,
  output logic          wb_stall,
  input  logic [N-1:0]  gpio_i,
  output logic [N-1:0]  gpio_o,
  output logic [N-1:0]  gpio_oe,
  output logic          irq
);

  logic          req;
  logic          wr;
  logic [2:0]    addr;
  logic [31:0]   sel_mask;
  logic [N-1:0]  wmask;
  logic [N-1:0]  wdat;

  assign req      = wb_cyc & wb_stb;
  assign wr       = req & wb_we;
  assign addr     = wb_adr[4:2];
  assign sel_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
  assign wmask    = sel_mask[N-1:0];
  assign wdat     = wb_dat_i[N-1:0];

  logic unused_ok;
  assign unused_ok = ^{wb_adr[31:5], wb_adr[1:0], wb_dat_i, sel_mask};

  logic [N-1:0] data_out_q, data_out_d;
  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] rise_en_q, rise_en_d;
  logic [N-1:0] fall_en_q, fall_en_d;
  logic [N-1:0] status_q, status_d;
  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] filt_q, filt_d;
  logic         ack_q;
  logic [31:0]  dat_q, dat_d;
  logic [31:0]  rdata;
  logic [N-1:0] rise, fall, w1c;

  // Input filter: either a plain register stage or a two-tick agreement debouncer.
  if (DB_DIV == 0) begin : g_bypass
    assign filt_d = sync2_q;
  end else begin : g_debounce
    localparam int unsigned PresWidth = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam logic [PresWidth-1:0] PresLast = PresWidth'(DB_DIV - 1);

    logic [PresWidth-1:0] presc_q, presc_d;
    logic [N-1:0]         samp_q, samp_d;
    logic                 tick;
    logic [N-1:0]         agree;

    assign tick  = (presc_q == PresLast);
    assign agree = ~(sync2_q ^ samp_q);

    always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      samp_d  = tick ? sync2_q : samp_q;
      filt_d  = filt_q;
      // A bit only follows s2 when the previous tick saw the same level.
      if (tick) begin
        filt_d = (agree & sync2_q) | (~agree & filt_q);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
        samp_q  <= '0;
      end else begin
        presc_q <= presc_d;
        samp_q  <= samp_d;
      end
    end
  end

  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;
  assign w1c  = (wr && addr == 3'd5) ? (wmask & wdat) : '0;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    if (wr) begin
      case (addr)
        3'd1:    data_out_d = (data_out_q & ~wmask) | (wdat & wmask);
        3'd2:    dir_d      = (dir_q & ~wmask) | (wdat & wmask);
        3'd3:    rise_en_d  = (rise_en_q & ~wmask) | (wdat & wmask);
        3'd4:    fall_en_d  = (fall_en_q & ~wmask) | (wdat & wmask);
        default: ;
      endcase
    end
    // New events are ORed in after the clear so a simultaneous set wins.
    status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0:    rdata = 32'(filt_q);
      3'd1:    rdata = 32'(data_out_q);
      3'd2:    rdata = 32'(dir_q);
      3'd3:    rdata = 32'(rise_en_q);
      3'd4:    rdata = 32'(fall_en_q);
      3'd5:    rdata = 32'(status_q);
      default: rdata = '0;
    endcase
    dat_d = req ? rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      ack_q      <= req;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_stall = 1'b0;
  assign gpio_o   = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |status_q;

endmodule
